// File: rtl/pht_ctrl.sv
// PHT sequencing controller: speculative GHR, gshare lookup index, and a small
// update FIFO drained as saturating read-modify-write cycles. PHT_INIT_SWEEP_EN adds the reset init sweep.
module pht_ctrl #(
  parameter int unsigned S_INDEX    = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pred_valid,
  input  logic [31:0]        pred_pc,
  output logic               pred_taken,
  output logic [S_INDEX-1:0] pred_ghr,
  input  logic               upd_valid,
  input  logic [31:0]        upd_pc,
  input  logic [S_INDEX-1:0] upd_ghr,
  input  logic               upd_taken,
  input  logic               upd_mispredict,
  output logic               upd_ready,
  output logic               busy,
  output logic               pht_load,
  output logic [S_INDEX-1:0] pht_bpindex,
  output logic [S_INDEX-1:0] pht_rindex,
  output logic [S_INDEX-1:0] pht_windex,
  output logic [1:0]         pht_datain,
  input  logic [1:0]         pht_bpdataout,
  input  logic [1:0]         pht_dataout
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 2 * S_INDEX + 1;

  logic [S_INDEX-1:0] ghr;
  logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [EW-1:0]      head;
  logic [S_INDEX-1:0] drain_idx;
  logic               head_taken;
  logic [1:0]         sat_val;
  logic               unused_bits;

  assign unused_bits = ^{pred_pc[31:S_INDEX+2], pred_pc[1:0],
                         upd_pc[31:S_INDEX+2], upd_pc[1:0], pht_bpdataout[0]};

`ifdef PHT_INIT_SWEEP_EN
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic [S_INDEX-1:0] sweep_i;
  logic [S_INDEX-1:0] sweep_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      sweep_i <= '0;
    end else begin
      state   <= state_nxt;
      sweep_i <= sweep_nxt;
    end
  end

  // Sweep every index once, then hand over to normal operation
  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_i;
    if (state == INIT) begin
      sweep_nxt = sweep_i + S_INDEX'(1);
      if (sweep_i == '1) state_nxt = RUN;
    end
  end

  assign busy = (state == INIT);
`else
  assign busy = 1'b0;
`endif

  // Lookup path
  assign pht_bpindex = pred_pc[S_INDEX+1:2] ^ ghr;
  assign pred_ghr    = ghr;
  assign pred_taken  = pht_bpdataout[1] & ~busy;

  // Update FIFO
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign upd_ready = ~full & ~busy;
  assign push      = upd_valid & upd_ready;
  assign pop       = ~empty & ~busy;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {upd_pc[S_INDEX+1:2], upd_ghr, upd_taken};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head       = fifo_mem[rd_ptr];
  assign drain_idx  = head[EW-1:S_INDEX+1] ^ head[S_INDEX:1];
  assign head_taken = head[0];

  // Two-bit saturating counter step
  always_comb begin
    sat_val = pht_dataout;
    if (head_taken) begin
      if (pht_dataout != 2'b11) sat_val = pht_dataout + 2'd1;
    end else begin
      if (pht_dataout != 2'b00) sat_val = pht_dataout - 2'd1;
    end
  end

  // Array write port: init sweep takes priority over draining
  always_comb begin
    pht_load   = 1'b0;
    pht_rindex = '0;
    pht_windex = '0;
    pht_datain = 2'b00;
`ifdef PHT_INIT_SWEEP_EN
    if (busy) begin
      pht_load   = 1'b1;
      pht_windex = sweep_i;
      pht_datain = 2'b01;
    end else
`endif
    if (pop) begin
      pht_load   = 1'b1;
      pht_rindex = drain_idx;
      pht_windex = drain_idx;
      pht_datain = sat_val;
    end
  end

  // A resolved mispredict repairs history and overrides the speculative shift
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (push && upd_mispredict) begin
      ghr <= {upd_ghr[S_INDEX-2:0], upd_taken};
    end else if (pred_valid && !busy) begin
      ghr <= {ghr[S_INDEX-2:0], pred_taken};
    end
  end

endmodule
